// File: rtl/jump_redirect_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// jump_redirect_ctrl_pkg
// Shared definitions for the jump/branch redirect controller: the FSM state
// encoding (also consumed by the hazard unit), PC arithmetic constants and
// the branch offset helper.
// ----------------------------------------------------------------------------
package jump_redirect_ctrl_pkg;

    // Control-transfer sequencing states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,  // no control transfer in flight
        RS_WAIT  = 2'd1,  // register jump waiting for its forwarded rs value
        DS_WAIT  = 2'd2,  // target captured, waiting for the delay slot fetch
        REDIRECT = 2'd3   // presenting the new PC to fetch
    } state_t;

    localparam logic [31:0] PC_STEP     = 32'd4;  // next sequential instruction
    localparam logic [31:0] LINK_OFFSET = 32'd8;  // return address skips the delay slot

    // Branch displacement: word offset, sign-extended to a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/jump_redirect_ctrl_target_calc.sv
// ----------------------------------------------------------------------------
// jump_redirect_ctrl_target_calc
// Purely combinational target selection for a control transfer.
//   i_pc           : address of the jump/branch
//   i_instr_index  : 26-bit J-type index
//   i_imm          : 16-bit branch immediate
//   i_rs_val       : register operand for JR/JALR
//   i_is_branch    : instruction is a conditional branch
//   i_jump_to_rs   : instruction jumps through a register
//   o_target       : resulting target address (mod 2^32)
// ----------------------------------------------------------------------------
module jump_redirect_ctrl_target_calc
    import jump_redirect_ctrl_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [25:0] i_instr_index,
    input  logic [15:0] i_imm,
    input  logic [31:0] i_rs_val,
    input  logic        i_is_branch,
    input  logic        i_jump_to_rs,
    output logic [31:0] o_target
);

    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = i_pc + PC_STEP;

    // NOTE: every output of an always_comb block gets a value on every path
    // (here via the if/else chain) so no latch is inferred.
    always_comb begin
        if (i_jump_to_rs) begin
            o_target = i_rs_val;
        end else if (i_is_branch) begin
            o_target = w_pc_plus4 + branch_offset(i_imm);
        end else begin
            // J/JAL stay inside the 256 MB region of the delay slot.
            o_target = {w_pc_plus4[31:28], i_instr_index, 2'b00};
        end
    end

endmodule

// File: rtl/jump_redirect_ctrl.sv
// ----------------------------------------------------------------------------
// jump_redirect_ctrl
// Sequences taken jumps/branches: captures the target, waits for a late rs
// operand if needed, waits for the delay slot fetch, then hands the new PC to
// fetch through a valid/ready handshake. Also produces the link register write
// for JAL/JALR/BGEZAL-class instructions and flags the delay slot in ID.
//   clk, rst            : clock, synchronous active-high reset
//   id_valid/id_accept  : ID holds an instruction / it advances this cycle
//   id_is_jump ...      : decode classification of the ID instruction
//   id_pc ... id_rd     : ID operands; rs_ready qualifies id_rs_val
//   ds_fetched          : fetch returned the delay slot word
//   flush               : exception/ERET flush, highest priority
//   redirect_*          : PC redirect handshake to fetch
//   id_stall            : hold ID (register jump waiting for rs)
//   ds_flag             : instruction in ID is a delay slot
//   link_*              : link register write port
// ----------------------------------------------------------------------------
module jump_redirect_ctrl
    import jump_redirect_ctrl_pkg::*;
#(
    parameter logic [4:0] RA_REG = 5'd31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        id_accept,
    input  logic        id_is_jump,
    input  logic        id_is_branch,
    input  logic        id_branch_taken,
    input  logic        id_jump_to_rs,
    input  logic        id_jsave,
    input  logic        id_save_in_rd,
    input  logic [31:0] id_pc,
    input  logic [25:0] id_instr_index,
    input  logic [15:0] id_imm,
    input  logic [31:0] id_rs_val,
    input  logic [4:0]  id_rd,
    input  logic        rs_ready,
    input  logic        ds_fetched,
    input  logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        id_stall,
    output logic        ds_flag,
    output logic        link_we,
    output logic [4:0]  link_waddr,
    output logic [31:0] link_wdata
);

    state_t      r_state;
    logic [31:0] r_target;
    logic        r_ds_seen;     // delay slot fetch already returned
    logic        r_ds_pending;  // next instruction in ID is a delay slot

    state_t      w_next_state;
    logic        w_ct;
    logic        w_capture;
    logic [31:0] w_capture_val;
    logic        w_stall;
    logic        w_adv;
    logic        w_ds_seen_next;
    logic        w_ds_pending_next;
    logic [31:0] w_target;
    logic [4:0]  w_link_waddr;

    jump_redirect_ctrl_target_calc u_target_calc (
        .i_pc          (id_pc),
        .i_instr_index (id_instr_index),
        .i_imm         (id_imm),
        .i_rs_val      (id_rs_val),
        .i_is_branch   (id_is_branch),
        .i_jump_to_rs  (id_jump_to_rs),
        .o_target      (w_target)
    );

    assign w_ct = id_valid && id_accept &&
                  (id_is_jump || (id_is_branch && id_branch_taken));

    always_comb begin
        w_next_state  = r_state;
        w_capture     = 1'b0;
        w_capture_val = w_target;
        w_stall       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ct) begin
                    if (id_jump_to_rs && !rs_ready) begin
                        w_next_state = RS_WAIT;
                        w_stall      = 1'b1;
                    end else begin
                        w_next_state = DS_WAIT;
                        w_capture    = 1'b1;
                    end
                end
            end
            RS_WAIT: begin
                // The register jump is held in ID, so its rs value is still on id_rs_val.
                if (rs_ready) begin
                    w_next_state  = DS_WAIT;
                    w_capture     = 1'b1;
                    w_capture_val = id_rs_val;
                end else begin
                    w_stall = 1'b1;
                end
            end
            DS_WAIT: begin
                if (r_ds_seen || ds_fetched) begin
                    w_next_state = REDIRECT;
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
        if (flush) begin
            w_next_state = IDLE;
            w_capture    = 1'b0;
        end
    end

    // An instruction leaves ID only when it is not being held by the rs stall.
    assign w_adv = id_valid && id_accept && !w_stall;

    // ds_seen lives only while a transfer is in flight; any return to IDLE drops it.
    assign w_ds_seen_next = (flush || (w_next_state == IDLE)) ? 1'b0
                                                              : (r_ds_seen || ds_fetched);

    // Jump/branch bits of instructions arriving in DS_WAIT/REDIRECT are delay
    // slot or wrong-path contents and do not open a new delay slot. RS_WAIT is
    // included because the instruction advancing there is the held jump itself.
    always_comb begin
        w_ds_pending_next = r_ds_pending;
        if (flush) begin
            w_ds_pending_next = 1'b0;
        end else if (w_adv) begin
            w_ds_pending_next = (id_is_jump || id_is_branch) &&
                                ((r_state == IDLE) || (r_state == RS_WAIT));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_target     <= '0;
            r_ds_seen    <= 1'b0;
            r_ds_pending <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_ds_seen    <= w_ds_seen_next;
            r_ds_pending <= w_ds_pending_next;
            if (w_capture) begin
                r_target <= w_capture_val;
            end
        end
    end

    assign w_link_waddr = id_save_in_rd ? id_rd : RA_REG;

    // Outputs are forced low during reset and flush; the link write happens
    // once, in IDLE, when the saving instruction is first accepted.
    assign redirect_valid = !rst && !flush && (r_state == REDIRECT);
    assign redirect_pc    = rst ? 32'd0 : r_target;
    assign id_stall       = !rst && !flush && w_stall;
    assign ds_flag        = !rst && !flush && r_ds_pending && id_valid;
    assign link_we        = !rst && !flush && (r_state == IDLE) && id_valid &&
                            id_accept && id_jsave && (w_link_waddr != 5'd0);
    assign link_waddr     = rst ? 5'd0 : w_link_waddr;
    assign link_wdata     = rst ? 32'd0 : (id_pc + LINK_OFFSET);

endmodule
